word_fetch: RTL and testbench
=============================

Name: word_fetch

Overview:
- Consumes the 5-bit pseudo-random value from the random-number stage.
- On a start request, it qualifies that value as a legal word index. A value is legal when it is inside the bank size and differs from the previous word's index.
- It then addresses the ROM word bank, waits the ROM read latency and captures the word.
- It holds the word with a valid/ack handshake for the game-logic stage downstream.

Parameters:
- ADDR_W, 5, width of random input, word index and ROM address.
- WORD_W, 40, ROM word width (5 characters x 8 bits).
- NUM_WORDS, 20, number of populated ROM entries; legal indices are 0..NUM_WORDS-1 (1..2**ADDR_W).
- ROM_LAT, 1, ROM read latency in clock cycles (>=1).
- MAX_RETRY, 8, rejected samples tolerated before the fallback index is forced (>=1).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start, input, 1, request a new word; sampled only in IDLE, or in HOLD together with word_ack.
- rnd_in, input, ADDR_W, pseudo-random value from the random-number stage; changes every cycle.
- rom_addr, output, ADDR_W, registered ROM word-bank address.
- rom_data, input, WORD_W, ROM read data, valid ROM_LAT cycles after rom_addr changes.
- word_out, output, WORD_W, captured word; stable throughout HOLD.
- word_index, output, ADDR_W, index of word_out.
- word_valid, output, 1, high in HOLD.
- word_ack, input, 1, downstream consumed word; meaningful only while word_valid=1.
- busy, output, 1, high in SAMPLE and READ.

Behaviour:
- Reset (reset=1 at an edge, any state, including mid-fetch):
  - State goes to IDLE.
  - rom_addr, word_out and word_index clear to 0.
  - word_valid=0, busy=0.
  - Retry count and wait count clear to 0.
  - have_last clears to 0.
- States: IDLE, SAMPLE, READ, HOLD.
- IDLE:
  - start=1 -> SAMPLE; retry count cleared.
  - Otherwise stay in IDLE.
- SAMPLE (one evaluation per cycle, against the current rnd_in):
  - Accept when rnd_in < NUM_WORDS and (have_last=0 or rnd_in != word_index).
  - Accept -> rom_addr<=rnd_in, wait count cleared, go to READ.
  - Reject -> retry count+1, stay in SAMPLE.
  - When a reject would make the retry count equal MAX_RETRY, force the fallback instead and go to READ. Fallback = (word_index+1) mod NUM_WORDS if have_last=1, else 0.
  - Comparison is unsigned, full ADDR_W width; no truncation.
- READ:
  - Stays exactly ROM_LAT cycles.
  - On the edge ending the last READ cycle: word_out<=rom_data, word_index<=rom_addr, have_last<=1, go to HOLD.
  - start is ignored in SAMPLE and READ (no queuing).
- HOLD:
  - word_valid=1; word_out and word_index are held.
  - word_ack=1 and start=0 -> IDLE.
  - word_ack=1 and start=1 -> SAMPLE directly (back-to-back fetch); retry count cleared.
  - start without word_ack is ignored.
- Latency:
  - Accept on the first sample: start at edge t gives SAMPLE in cycle t+1, rom_addr valid from t+2, word_valid high from t+2+ROM_LAT.
  - Each rejection adds 1 cycle.
  - Worst case = start + MAX_RETRY samples + ROM_LAT.
- rom_addr changes only on accept or fallback; it holds its value otherwise.

Test Plan:
- Basic fetch:
  - Stimulus: ROM_LAT=1; reset, then start with rnd_in=7; ROM[7]=40'h48454C4C4F.
  - Required: word_valid rises 3 cycles after the start edge; word_out=40'h48454C4C4F, word_index=7.
  - Then word_ack -> IDLE, word_valid=0 next cycle.
- Out-of-range rejection:
  - Stimulus: rnd_in sequence 25,31,20,3 (NUM_WORDS=20).
  - Required: three SAMPLE cycles rejected; rom_addr=3; busy high throughout; word_index=3.
- Repeat rejection and fallback:
  - Stimulus: previous index 3; hold rnd_in=3 for 8 cycles.
  - Required: fallback forced after MAX_RETRY; word_index=4.
  - With previous index 19, same stimulus: word_index=0 (wrap).
- Handshake corners:
  - start asserted in READ -> ignored.
  - start in HOLD without ack -> word_valid stays 1, word_out unchanged.
  - word_ack+start together -> next cycle busy=1, word_valid=0.
- Reset mid-operation:
  - Stimulus: reset asserted in READ.
  - Required: next cycle IDLE, all outputs 0.
  - Following start with rnd_in equal to the pre-reset index is accepted first time (have_last cleared).
- Latency sweep:
  - Stimulus: ROM_LAT=3.
  - Required: word_valid 5 cycles after the start edge; captured data equals ROM data at the accepted address.

Source files
------------

// File: rtl/word_fetch.sv
// -----------------------------------------------------------------------------
// word_fetch
//
// Picks the next word for the game from a ROM word bank. On a start request
// the 5-bit pseudo-random value coming from the random-number stage is
// qualified as a word index. A value qualifies when it lies inside the
// populated part of the bank and differs from the index of the previous word.
// Rejected values are retried on the following cycles with whatever the
// random stage offers next. After MAX_RETRY rejections a deterministic
// fallback index is used so that the fetch always completes. The chosen index
// is driven onto the ROM address and, after the ROM read latency, the word is
// captured and offered downstream with a valid/ack handshake.
//
// Ports
//   clock       in   1       system clock, rising edge
//   reset       in   1       synchronous active-high reset
//   start       in   1       request a new word (honoured in IDLE, or in HOLD
//                            together with word_ack)
//   rnd_in      in   ADDR_W  pseudo-random candidate index
//   rom_addr    out  ADDR_W  registered ROM word-bank address
//   rom_data    in   WORD_W  ROM read data, valid ROM_LAT cycles after
//                            rom_addr changes
//   word_out    out  WORD_W  captured word, stable while word_valid is high
//   word_index  out  ADDR_W  index of word_out
//   word_valid  out  1       word is being offered (HOLD)
//   word_ack    in   1       downstream consumed the word
//   busy        out  1       a fetch is in progress (SAMPLE or READ)
// -----------------------------------------------------------------------------
module word_fetch #(
  parameter int ADDR_W    = 5,
  parameter int WORD_W    = 40,
  parameter int NUM_WORDS = 20,
  parameter int ROM_LAT   = 1,
  parameter int MAX_RETRY = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] rnd_in,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [WORD_W-1:0] rom_data,
  output logic [WORD_W-1:0] word_out,
  output logic [ADDR_W-1:0] word_index,
  output logic              word_valid,
  input  logic              word_ack,
  output logic              busy
);

  // Counter widths: the retry counter must be able to reach MAX_RETRY, the
  // wait counter only counts 0..ROM_LAT-1.
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int WAIT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY - 1);
  localparam logic [RETRY_W-1:0] RETRY_ONE  = RETRY_W'(1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(ROM_LAT - 1);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(NUM_WORDS - 1);

  // The range test is done one bit wider than the index so that a fully
  // populated bank (NUM_WORDS = 2**ADDR_W) does not wrap the bound to zero.
  localparam logic [ADDR_W:0] NUM_WORDS_EXT = (ADDR_W + 1)'(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_READ,
    S_HOLD
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   rom_addr_q,  rom_addr_d;
  logic [WORD_W-1:0]   word_q,      word_d;
  logic [ADDR_W-1:0]   index_q,     index_d;
  logic                have_last_q, have_last_d;
  logic [RETRY_W-1:0]  retry_q,     retry_d;
  logic [WAIT_W-1:0]   wait_q,      wait_d;

  logic                in_range;
  logic                not_repeat;
  logic                sample_ok;
  logic [ADDR_W-1:0]   fallback_idx;

  // Candidate qualification. Before the first completed fetch there is no
  // previous word, so any in-range value is acceptable.
  assign in_range   = ({1'b0, rnd_in} < NUM_WORDS_EXT);
  assign not_repeat = !have_last_q || (rnd_in != index_q);
  assign sample_ok  = in_range && not_repeat;

  // Fallback walks to the word after the previous one, wrapping at the end
  // of the populated bank; with no previous word it starts at entry 0.
  assign fallback_idx = !have_last_q        ? '0 :
                        (index_q == LAST_IDX) ? '0 :
                        index_q + ADDR_ONE;

  // State and datapath registers, all cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      word_q      <= '0;
      index_q     <= '0;
      have_last_q <= 1'b0;
      retry_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      word_q      <= word_d;
      index_q     <= index_d;
      have_last_q <= have_last_d;
      retry_q     <= retry_d;
      wait_q      <= wait_d;
    end
  end

  // Next-state logic. Everything holds by default; rom_addr only moves on an
  // accept or a fallback, and the word/index only move at the end of READ.
  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    word_d      = word_q;
    index_d     = index_q;
    have_last_d = have_last_q;
    retry_d     = retry_q;
    wait_d      = wait_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SAMPLE;
          retry_d = '0;
        end
      end

      S_SAMPLE: begin
        if (sample_ok) begin
          rom_addr_d = rnd_in;
          wait_d     = '0;
          state_d    = S_READ;
        end else if (retry_q == RETRY_LAST) begin
          // This rejection would reach the retry limit: take the fallback.
          rom_addr_d = fallback_idx;
          retry_d    = retry_q + RETRY_ONE;
          wait_d     = '0;
          state_d    = S_READ;
        end else begin
          retry_d = retry_q + RETRY_ONE;
        end
      end

      S_READ: begin
        if (wait_q == WAIT_LAST) begin
          word_d      = rom_data;
          index_d     = rom_addr_q;
          have_last_d = 1'b1;
          state_d     = S_HOLD;
        end else begin
          wait_d = wait_q + WAIT_ONE;
        end
      end

      S_HOLD: begin
        if (word_ack) begin
          if (start) begin
            state_d = S_SAMPLE;
            retry_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rom_addr   = rom_addr_q;
  assign word_out   = word_q;
  assign word_index = index_q;
  assign word_valid = (state_q == S_HOLD);
  assign busy       = (state_q == S_SAMPLE) || (state_q == S_READ);

endmodule

// File: tb/tb_word_fetch.sv
// -----------------------------------------------------------------------------
// tb_word_fetch
//
// Bench for word_fetch. Two instances share clock and reset: dut1 with a one
// cycle ROM and dut2 with a three cycle ROM. Each has its own ROM model and
// its own behavioural reference, and every cycle all outputs of both are
// compared against their references. Directed scenarios add hand-computed
// expectations on top.
// -----------------------------------------------------------------------------
module tb_word_fetch;

  localparam int AW = 5;
  localparam int WW = 40;
  localparam int NW = 20;
  localparam int MR = 8;

  // Reference phases.
  localparam logic [1:0] PH_IDLE   = 2'd0;
  localparam logic [1:0] PH_SAMPLE = 2'd1;
  localparam logic [1:0] PH_READ   = 2'd2;
  localparam logic [1:0] PH_HOLD   = 2'd3;

  typedef struct packed {
    logic [1:0]    phase;
    int            tries;
    int            left;
    logic          have;
    logic [AW-1:0] addr;
    logic [AW-1:0] idx;
    logic [WW-1:0] word;
  } mdl_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset;
  logic          start1, ack1, start2, ack2;
  logic [AW-1:0] rnd1, rnd2;
  logic [AW-1:0] romAddr1, romAddr2, wordIndex1, wordIndex2;
  logic [WW-1:0] romData1, romData2, wordOut1, wordOut2;
  logic          wordValid1, wordValid2, busy1, busy2;

  logic [WW-1:0] romTable [32];
  logic [WW-1:0] romPipeA, romPipeB;

  mdl_t m1, m2;
  int   checks = 0;
  int   failures = 0;
  bit   compareOn = 1'b0;
  int   n;

  // ROM for dut1: data follows the address within the same cycle.
  assign romData1 = romTable[romAddr1];

  // ROM for dut2: two extra register stages, so data for a new address is
  // only present on the third edge after the address changed.
  always @(posedge clock) begin
    romPipeA <= romTable[romAddr2];
    romPipeB <= romPipeA;
  end
  assign romData2 = romPipeB;

  word_fetch #(.ADDR_W(AW), .WORD_W(WW), .NUM_WORDS(NW), .ROM_LAT(1), .MAX_RETRY(MR)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .rnd_in(rnd1),
    .rom_addr(romAddr1), .rom_data(romData1), .word_out(wordOut1),
    .word_index(wordIndex1), .word_valid(wordValid1), .word_ack(ack1), .busy(busy1)
  );

  word_fetch #(.ADDR_W(AW), .WORD_W(WW), .NUM_WORDS(NW), .ROM_LAT(3), .MAX_RETRY(MR)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .rnd_in(rnd2),
    .rom_addr(romAddr2), .rom_data(romData2), .word_out(wordOut2),
    .word_index(wordIndex2), .word_valid(wordValid2), .word_ack(ack2), .busy(busy2)
  );

  // Behavioural reference: one clock edge of the fetch rules, with the word
  // taken straight from the ROM contents at the chosen index.
  function automatic mdl_t stepModel(mdl_t m, logic rst, logic st, logic [AW-1:0] rnd,
                                     logic ack, int lat);
    mdl_t nx;
    nx = m;
    if (rst) begin
      nx = '0;
      return nx;
    end
    case (m.phase)
      PH_IDLE: begin
        if (st) begin
          nx.phase = PH_SAMPLE;
          nx.tries = 0;
        end
      end
      PH_SAMPLE: begin
        if ((int'(rnd) < NW) && (!m.have || (rnd != m.idx))) begin
          nx.addr  = rnd;
          nx.left  = lat;
          nx.phase = PH_READ;
        end else if (m.tries + 1 >= MR) begin
          nx.addr  = m.have ? AW'((int'(m.idx) + 1) % NW) : '0;
          nx.left  = lat;
          nx.phase = PH_READ;
        end else begin
          nx.tries = m.tries + 1;
        end
      end
      PH_READ: begin
        nx.left = m.left - 1;
        if (nx.left == 0) begin
          nx.word  = romTable[m.addr];
          nx.idx   = m.addr;
          nx.have  = 1'b1;
          nx.phase = PH_HOLD;
        end
      end
      default: begin
        if (ack) begin
          nx.phase = st ? PH_SAMPLE : PH_IDLE;
          nx.tries = 0;
        end
      end
    endcase
    return nx;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against their references.
  task automatic compareAll();
    checkOutput("dut1.rom_addr",   64'(romAddr1),   64'(m1.addr));
    checkOutput("dut1.word_out",   64'(wordOut1),   64'(m1.word));
    checkOutput("dut1.word_index", 64'(wordIndex1), 64'(m1.idx));
    checkOutput("dut1.word_valid", 64'(wordValid1), 64'(m1.phase == PH_HOLD));
    checkOutput("dut1.busy",       64'(busy1),      64'(m1.phase == PH_SAMPLE || m1.phase == PH_READ));
    checkOutput("dut2.rom_addr",   64'(romAddr2),   64'(m2.addr));
    checkOutput("dut2.word_out",   64'(wordOut2),   64'(m2.word));
    checkOutput("dut2.word_index", 64'(wordIndex2), 64'(m2.idx));
    checkOutput("dut2.word_valid", 64'(wordValid2), 64'(m2.phase == PH_HOLD));
    checkOutput("dut2.busy",       64'(busy2),      64'(m2.phase == PH_SAMPLE || m2.phase == PH_READ));
  endtask

  // Drive dut1 inputs, advance one clock, step the references and compare
  // on the falling edge.
  task automatic applyStimulus(input logic st, input logic [AW-1:0] r, input logic a);
    start1 = st;
    rnd1   = r;
    ack1   = a;
    @(posedge clock);
    m1 = stepModel(m1, reset, start1, rnd1, ack1, 1);
    m2 = stepModel(m2, reset, start2, rnd2, ack2, 3);
    @(negedge clock);
    if (compareOn) compareAll();
  endtask

  // Idle dut1 until word_valid, counting cycles from the start edge (the
  // first cycle after the start edge is cycle 1). Bounded.
  task automatic waitValid1(input logic [AW-1:0] r, output int cnt);
    cnt = 1;
    while (!wordValid1 && cnt < 50) begin
      applyStimulus(1'b0, r, 1'b0);
      cnt++;
    end
    if (!wordValid1) checkOutput("dut1.valid_timeout", 64'(0), 64'(1));
  endtask

  task automatic waitValid2(output int cnt);
    cnt = 1;
    while (!wordValid2 && cnt < 50) begin
      applyStimulus(1'b0, '0, 1'b0);
      cnt++;
    end
    if (!wordValid2) checkOutput("dut2.valid_timeout", 64'(0), 64'(1));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) romTable[i] = {32'h574F5244, 8'(8'h41 + i)};
    romTable[7] = 40'h48454C4C4F;
    m1 = '0;
    m2 = '0;
    reset = 1'b1;
    start1 = 1'b0; ack1 = 1'b0; rnd1 = '0;
    start2 = 1'b0; ack2 = 1'b0; rnd2 = '0;

    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0);
    reset = 1'b0;
    compareOn = 1'b1;
    checkOutput("reset.word_valid", 64'(wordValid1), 64'(0));
    checkOutput("reset.busy",       64'(busy1),      64'(0));
    checkOutput("reset.rom_addr",   64'(romAddr1),   64'(0));
    checkOutput("reset.word_out",   64'(wordOut1),   64'(0));
    checkOutput("reset.word_index", 64'(wordIndex1), 64'(0));

    // Basic fetch of index 7.
    applyStimulus(1'b1, 5'd7, 1'b0);
    checkOutput("basic.busy_sample", 64'(busy1), 64'(1));
    waitValid1(5'd7, n);
    checkOutput("basic.latency",    64'(n),          64'(3));
    checkOutput("basic.word_out",   64'(wordOut1),   64'h48454C4C4F);
    checkOutput("basic.word_index", 64'(wordIndex1), 64'(7));
    applyStimulus(1'b0, 5'd7, 1'b1);
    checkOutput("basic.valid_after_ack", 64'(wordValid1), 64'(0));
    checkOutput("basic.busy_after_ack",  64'(busy1),      64'(0));

    // Out-of-range values are rejected; 20 is the first illegal index.
    applyStimulus(1'b1, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd25, 1'b0);
    checkOutput("range.busy_25", 64'(busy1), 64'(1));
    applyStimulus(1'b0, 5'd31, 1'b0);
    checkOutput("range.busy_31", 64'(busy1), 64'(1));
    applyStimulus(1'b0, 5'd20, 1'b0);
    checkOutput("range.busy_20",     64'(busy1),    64'(1));
    checkOutput("range.addr_held",   64'(romAddr1), 64'(7));
    applyStimulus(1'b0, 5'd3, 1'b0);
    checkOutput("range.addr_accept", 64'(romAddr1), 64'(3));
    checkOutput("range.busy_read",   64'(busy1),    64'(1));
    applyStimulus(1'b0, 5'd3, 1'b0);
    checkOutput("range.word_index",  64'(wordIndex1), 64'(3));
    checkOutput("range.word_out",    64'(wordOut1),   64'h574F524444);
    applyStimulus(1'b0, 5'd3, 1'b1);

    // Repeat of index 3 for MAX_RETRY samples forces fallback to 4.
    applyStimulus(1'b1, 5'd3, 1'b0);
    for (int k = 1; k <= MR; k++) begin
      applyStimulus(1'b0, 5'd3, 1'b0);
      checkOutput("fallback.busy", 64'(busy1), 64'(1));
      if (k == MR - 1) checkOutput("fallback.addr_before", 64'(romAddr1), 64'(3));
    end
    checkOutput("fallback.addr", 64'(romAddr1), 64'(4));
    applyStimulus(1'b0, 5'd3, 1'b0);
    checkOutput("fallback.word_index", 64'(wordIndex1), 64'(4));

    // start in HOLD without ack is ignored.
    applyStimulus(1'b1, 5'd3, 1'b0);
    applyStimulus(1'b1, 5'd3, 1'b0);
    checkOutput("hold.valid_kept", 64'(wordValid1), 64'(1));
    checkOutput("hold.word_kept",  64'(wordOut1),   64'h574F524445);

    // ack with start goes straight back to sampling.
    applyStimulus(1'b1, 5'd19, 1'b1);
    checkOutput("b2b.busy",  64'(busy1),      64'(1));
    checkOutput("b2b.valid", 64'(wordValid1), 64'(0));
    applyStimulus(1'b0, 5'd19, 1'b0);
    checkOutput("b2b.addr", 64'(romAddr1), 64'(19));
    // start during READ must not be remembered.
    applyStimulus(1'b1, 5'd19, 1'b0);
    checkOutput("b2b.word_index", 64'(wordIndex1), 64'(19));
    applyStimulus(1'b0, 5'd19, 1'b1);
    applyStimulus(1'b0, 5'd19, 1'b0);
    checkOutput("readstart.busy",  64'(busy1),      64'(0));
    checkOutput("readstart.valid", 64'(wordValid1), 64'(0));

    // Fallback after index 19 wraps to 0.
    applyStimulus(1'b1, 5'd19, 1'b0);
    for (int k = 1; k <= MR; k++) applyStimulus(1'b0, 5'd19, 1'b0);
    applyStimulus(1'b0, 5'd19, 1'b0);
    checkOutput("wrap.word_index", 64'(wordIndex1), 64'(0));
    checkOutput("wrap.word_valid", 64'(wordValid1), 64'(1));
    applyStimulus(1'b0, 5'd19, 1'b1);

    // Reset in the middle of a fetch.
    applyStimulus(1'b1, 5'd5, 1'b0);
    applyStimulus(1'b0, 5'd5, 1'b0);
    checkOutput("midreset.in_read", 64'(romAddr1), 64'(5));
    reset = 1'b1;
    applyStimulus(1'b0, 5'd5, 1'b0);
    reset = 1'b0;
    checkOutput("midreset.busy",     64'(busy1),      64'(0));
    checkOutput("midreset.valid",    64'(wordValid1), 64'(0));
    checkOutput("midreset.rom_addr", 64'(romAddr1),   64'(0));
    checkOutput("midreset.word_out", 64'(wordOut1),   64'(0));
    // Index 0 equals the pre-reset index but must be accepted at once.
    applyStimulus(1'b1, 5'd0, 1'b0);
    waitValid1(5'd0, n);
    checkOutput("midreset.latency",    64'(n),          64'(3));
    checkOutput("midreset.word_index", 64'(wordIndex1), 64'(0));
    applyStimulus(1'b0, 5'd0, 1'b1);

    // Three-cycle ROM on dut2.
    start2 = 1'b1;
    rnd2   = 5'd11;
    applyStimulus(1'b0, '0, 1'b0);
    start2 = 1'b0;
    waitValid2(n);
    checkOutput("lat3.latency",    64'(n),          64'(5));
    checkOutput("lat3.word_out",   64'(wordOut2),   64'h574F52444C);
    checkOutput("lat3.word_index", 64'(wordIndex2), 64'(11));
    // Back-to-back fetch with one repeat rejection before accepting 12.
    ack2   = 1'b1;
    start2 = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    ack2   = 1'b0;
    start2 = 1'b0;
    rnd2   = 5'd11;
    applyStimulus(1'b0, '0, 1'b0);
    rnd2   = 5'd12;
    n = 2;
    while (!wordValid2 && n < 50) begin
      applyStimulus(1'b0, '0, 1'b0);
      n++;
    end
    checkOutput("lat3.retry_latency", 64'(n),          64'(6));
    checkOutput("lat3.retry_index",   64'(wordIndex2), 64'(12));
    checkOutput("lat3.retry_word",    64'(wordOut2),   64'h574F52444D);
    ack2 = 1'b1;
    applyStimulus(1'b0, '0, 1'b0);
    ack2 = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
